// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-iteration signed multiply / restoring divide with HI/LO result registers.
// Optional MULTDIV_UNSIGNED_EN adds the uns input for multu/divu.
module mult_div_unit (
    input  logic        clock,
    input  logic        Reset,
    input  logic        start_mult,
    input  logic        start_div,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic        uns,
`endif
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
    state_t      state;
    logic [63:0] acc;
    logic [31:0] rem, mb;
    logic [5:0]  cnt;
    logic        sp, sr, dz, is_div, sgn;
    logic [31:0] abs_a, abs_b;
    logic [32:0] sum, shl, diff;
    logic [63:0] prod;
`ifdef MULTDIV_UNSIGNED_EN
    assign sgn = ~uns;
`else
    assign sgn = 1'b1;
`endif
    assign abs_a = (sgn & a[31]) ? -a : a;
    assign abs_b = (sgn & b[31]) ? -b : b;
    assign sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mb} : 33'd0);
    assign shl   = {rem, acc[31]};
    assign diff  = shl - {1'b0, mb};
    assign prod  = sp ? -acc : acc;
    always_ff @(posedge clock) begin
        if (Reset) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE also accepts a new start so back-to-back ops lose no cycle
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    cnt      <= '0;
                    rem      <= '0;
                    acc      <= {32'd0, abs_a};
                    mb       <= abs_b;
                    sp       <= sgn & (a[31] ^ b[31]);
                    sr       <= sgn & a[31];
                    is_div   <= ~start_mult;
                    dz       <= ~start_mult & (b == 32'd0);
                    busy     <= start_mult | start_div;
                    state    <= start_mult ? MULT : start_div ? ((b == 32'd0) ? FIX : DIV) : IDLE;
                end
                MULT: begin
                    acc   <= {sum, acc[31:1]};
                    cnt   <= cnt + 6'd1;
                    state <= (cnt == 6'd31) ? FIX : MULT;
                end
                DIV: begin
                    rem        <= diff[32] ? shl[31:0] : diff[31:0];
                    acc[31:0]  <= {acc[30:0], ~diff[32]};
                    cnt        <= cnt + 6'd1;
                    state      <= (cnt == 6'd31) ? FIX : DIV;
                end
                FIX: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (!dz) begin
                        hi <= is_div ? (sr ? -rem : rem) : prod[63:32];
                        lo <= is_div ? (sp ? -acc[31:0] : acc[31:0]) : prod[31:0];
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed plus randomized checks of mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
    logic        clock = 1'b0, Reset = 1'b1, start_mult = 1'b0, start_div = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
    logic        uns_v = 1'b0;
    int          n_cmp = 0, n_err = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    mult_div_unit dut (
        .clock(clock), .Reset(Reset), .start_mult(start_mult), .start_div(start_div),
`ifdef MULTDIV_UNSIGNED_EN
        .uns(uns_v),
`endif
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic op(input bit is_div, input bit both, input logic [31:0] x, input logic [31:0] y, input bit inject);
        longint      sx, sy, q, r;
        logic [63:0] p;
        bit          dz;
        int          n, lat;
        sx = uns_v ? longint'({32'd0, x}) : longint'($signed(x));
        sy = uns_v ? longint'({32'd0, y}) : longint'($signed(y));
        dz = is_div && !both && y == 32'd0;
        if (!is_div || both) begin
            p = sx * sy;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (!dz) begin
            q = sx / sy;
            r = sx % sy;
            p = q;
            exp_lo = p[31:0];
            p = r;
            exp_hi = p[31:0];
        end
        lat = dz ? 1 : 33;
        @(negedge clock);
        a = x; b = y;
        start_mult = !is_div || both;
        start_div = is_div || both;
        @(posedge clock);
        #1;
        start_mult = 1'b0; start_div = 1'b0;
        a = $urandom; b = $urandom;
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 50) begin
            if (inject && n == 5) begin
                start_mult = 1'b1;
                start_div = 1'($urandom);
            end
            @(posedge clock);
            #1;
            start_mult = 1'b0; start_div = 1'b0;
            n++;
        end
        chk("latency", n, lat);
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
        chk("div_zero", div_zero, dz);
        chk("busy_at_done", busy, 0);
        @(posedge clock);
        #1;
        chk("done_falls", done, 0);
        chk("div_zero_falls", div_zero, 0);
    endtask

    initial begin
        int n;
        bit seen;
        repeat (2) @(posedge clock);
        #1;
        Reset = 1'b0;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        op(0, 0, 32'hFFFFFFFF, 32'h00000002, 0);
        chk("plan_mul_hi", hi, 32'hFFFFFFFF);
        chk("plan_mul_lo", lo, 32'hFFFFFFFE);
        op(1, 0, 32'hFFFFFFF9, 32'h00000002, 0);
        chk("plan_div_lo", lo, 32'hFFFFFFFD);
        chk("plan_div_hi", hi, 32'hFFFFFFFF);
        op(0, 0, 32'h11111111, 32'h00000001, 0);
        op(1, 0, 32'h22222222, 32'h00000001, 0);
        chk("prep_lo", lo, 32'h22222222);
        op(1, 0, 32'h00000005, 32'h00000000, 0);
        chk("dz_lo_kept", lo, 32'h22222222);
        op(1, 1, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("coll_hi", hi, 32'h00000000);
        chk("coll_lo", lo, 32'h80000000);
        op(1, 0, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);
        op(1, 0, 32'h00000007, 32'hFFFFFFFE, 0);
        op(0, 0, 32'h80000000, 32'h80000000, 1);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom);
`ifdef MULTDIV_UNSIGNED_EN
            uns_v = 1'($urandom);
`endif
            op(1'($urandom), ($urandom_range(0, 5) == 0), x, y, 1'($urandom));
        end
`ifdef MULTDIV_UNSIGNED_EN
        uns_v = 1'b1;
        op(0, 0, 32'hFFFFFFFF, 32'h00000002, 1);
        chk("uns_hi", hi, 32'h00000001);
        chk("uns_lo", lo, 32'hFFFFFFFE);
        uns_v = 1'b0;
`endif
        @(negedge clock);
        a = 32'd3; b = 32'd4; start_mult = 1'b1;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        Reset = 1'b1;
        @(posedge clock);
        #1;
        Reset = 1'b0;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", busy, 0);
        exp_hi = '0; exp_lo = '0;
        seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            seen |= done | busy;
        end
        chk("midrst_no_done", seen, 0);
        op(0, 0, 32'd3, 32'd4, 0);
        chk("after_rst_lo", lo, 32'd12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
